// File: rtl/stage_fetch.sv
// rtl/stage_fetch.sv - instruction fetch stage with in-order fetch queue and IF/DE register
//
// Purpose: owns the PC, issues word fetches to instruction memory (variable
// latency, in-order responses), buffers up to FIFO_DEPTH fetches and feeds the
// IF/DE pipeline register. Handles stall/clear from the hazard unit and PC
// redirect from execute; responses for a squashed path are discarded.
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   de_stall, de_clear         hold / bubble the IF/DE register
//   ex_pc_src, ex_pc_target    redirect request and target from execute
//   imem_req, imem_addr        fetch request and word-aligned address
//   imem_ready                 memory accepts the request this cycle
//   imem_rvalid, imem_rdata    in-order fetch response
//   de_instr, de_pc, de_pc_plus4  IF/DE register outputs
//   fetch_empty                queue head not ready to hand to decode
module stage_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_stall,
  input  logic        de_clear,
  input  logic        ex_pc_src,
  input  logic [31:0] ex_pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] de_instr,
  output logic [31:0] de_pc,
  output logic [31:0] de_pc_plus4,
  output logic        fetch_empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // State
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;    // oldest allocated-but-unfilled entry
  logic [CNT_W-1:0] count_q, count_d;          // allocated entries
  logic [CNT_W-1:0] unfilled_q, unfilled_d;    // allocated entries still awaiting data
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;    // responses owed to a squashed path

  logic [31:0]           ent_pc_q    [FIFO_DEPTH];
  logic [31:0]           ent_pc_d    [FIFO_DEPTH];
  logic [31:0]           ent_instr_q [FIFO_DEPTH];
  logic [31:0]           ent_instr_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_filled_q, ent_filled_d;

  logic [31:0] de_instr_q, de_instr_d;
  logic [31:0] de_pc_q, de_pc_d;
  logic [31:0] de_pc_plus4_q, de_pc_plus4_d;

  // Handshake decode
  logic head_filled;
  logic accept;
  logic rsp;
  logic drop;
  logic fill;
  logic pop;

  // Low target bits are forced to zero, so they are intentionally ignored.
  logic unused_tgt_bits;
  assign unused_tgt_bits = ^ex_pc_target[1:0];

  assign head_filled = (count_q != '0) & ent_filled_q[head_q];
  assign fetch_empty = ~head_filled;

  assign imem_req  = rst_n & ~ex_pc_src & (count_q < DEPTH_C) & (outstanding_q < DEPTH_C);
  assign imem_addr = pc_q;
  assign accept    = imem_req & imem_ready;

  // A response with nothing outstanding is stale (e.g. from before reset).
  assign rsp  = imem_rvalid & (outstanding_q != '0);
  assign drop = rsp & (drop_cnt_q != '0);
  assign fill = rsp & (drop_cnt_q == '0) & (unfilled_q != '0);

  // Pop only from the final "load" branch of the IF/DE priority chain.
  assign pop = ~de_clear & ~de_stall & ~ex_pc_src & head_filled;

  assign de_instr    = de_instr_q;
  assign de_pc       = de_pc_q;
  assign de_pc_plus4 = de_pc_plus4_q;

  always_comb begin
    pc_d          = pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    fill_ptr_d    = fill_ptr_q;
    count_d       = count_q;
    unfilled_d    = unfilled_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    ent_pc_d      = ent_pc_q;
    ent_instr_d   = ent_instr_q;
    ent_filled_d  = ent_filled_q;

    // Outstanding tracks the memory side only; a redirect does not cancel
    // requests already accepted, it just marks their responses for dropping.
    if (accept) outstanding_d = outstanding_d + CNT_ONE;
    if (rsp)    outstanding_d = outstanding_d - CNT_ONE;
    if (drop)   drop_cnt_d    = drop_cnt_d - CNT_ONE;

    if (fill) begin
      ent_instr_d[fill_ptr_q]  = imem_rdata;
      ent_filled_d[fill_ptr_q] = 1'b1;
    end

    if (ex_pc_src) begin
      // Every response still owed to the queue, including one filling this
      // cycle, now belongs to the wrong path.
      pc_d       = {ex_pc_target[31:2], 2'b00};
      head_d     = tail_q;
      fill_ptr_d = tail_q;
      count_d    = '0;
      unfilled_d = '0;
      drop_cnt_d = drop_cnt_d + unfilled_q;
      if (fill) drop_cnt_d = drop_cnt_d - CNT_ONE;
    end else begin
      if (accept) begin
        ent_pc_d[tail_q]     = pc_q;
        ent_filled_d[tail_q] = 1'b0;
        tail_d               = tail_q + PTR_ONE;
        pc_d                 = pc_q + 32'd4;
        count_d              = count_d + CNT_ONE;
        unfilled_d           = unfilled_d + CNT_ONE;
      end
      if (fill) begin
        fill_ptr_d = fill_ptr_q + PTR_ONE;
        unfilled_d = unfilled_d - CNT_ONE;
      end
      if (pop) begin
        head_d  = head_q + PTR_ONE;
        count_d = count_d - CNT_ONE;
      end
    end
  end

  always_comb begin
    de_instr_d    = NOP_INSTR;
    de_pc_d       = '0;
    de_pc_plus4_d = '0;
    if (de_clear) begin
      de_instr_d    = NOP_INSTR;
    end else if (de_stall) begin
      de_instr_d    = de_instr_q;
      de_pc_d       = de_pc_q;
      de_pc_plus4_d = de_pc_plus4_q;
    end else if (ex_pc_src) begin
      de_instr_d    = NOP_INSTR;
    end else if (head_filled) begin
      de_instr_d    = ent_instr_q[head_q];
      de_pc_d       = ent_pc_q[head_q];
      de_pc_plus4_d = ent_pc_q[head_q] + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      fill_ptr_q    <= '0;
      count_q       <= '0;
      unfilled_q    <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      ent_filled_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_pc_q[i]    <= '0;
        ent_instr_q[i] <= '0;
      end
      de_instr_q    <= NOP_INSTR;
      de_pc_q       <= '0;
      de_pc_plus4_q <= '0;
    end else begin
      pc_q          <= pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fill_ptr_q    <= fill_ptr_d;
      count_q       <= count_d;
      unfilled_q    <= unfilled_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      ent_filled_q  <= ent_filled_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_pc_q[i]    <= ent_pc_d[i];
        ent_instr_q[i] <= ent_instr_d[i];
      end
      de_instr_q    <= de_instr_d;
      de_pc_q       <= de_pc_d;
      de_pc_plus4_q <= de_pc_plus4_d;
    end
  end

endmodule

// File: tb/tb_stage_fetch.sv
// tb/tb_stage_fetch.sv - directed table-driven bench for stage_fetch
module tb_stage_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de_stall, de_clear, ex_pc_src;
  logic [31:0] ex_pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] de_instr, de_pc, de_pc_plus4;
  logic        fetch_empty;

  stage_fetch #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .de_stall    (de_stall),
    .de_clear    (de_clear),
    .ex_pc_src   (ex_pc_src),
    .ex_pc_target(ex_pc_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .de_instr    (de_instr),
    .de_pc       (de_pc),
    .de_pc_plus4 (de_pc_plus4),
    .fetch_empty (fetch_empty)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory model: in-order responses, fixed latency in cycles.
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic        req_seen, acc_seen, rvalid_seen;
  logic [31:0] addr_seen;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    req_seen    = imem_req;
    addr_seen   = imem_addr;
    acc_seen    = imem_req & imem_ready;
    rvalid_seen = imem_rvalid;
    @(posedge clk);
    if (rvalid_seen) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (acc_seen) begin
      mq_addr.push_back(addr_seen);
      mq_due.push_back(cyc + lat);
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int l);
    rst_n        = 1'b0;
    de_stall     = 1'b0;
    de_clear     = 1'b0;
    ex_pc_src    = 1'b0;
    ex_pc_target = '0;
    imem_ready   = 1'b1;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    mq_addr.delete();
    mq_due.delete();
    lat = l;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Runs until the first real instruction reaches decode after a redirect.
  task automatic follow_redirect(input string tag, input logic [31:0] tgt,
                                 input logic [31:0] bad_a, input logic [31:0] bad_b);
    logic        got_acc, got_de, bad_seen;
    logic [31:0] first_addr, first_pc, first_instr;
    got_acc = 1'b0; got_de = 1'b0; bad_seen = 1'b0;
    first_addr = '0; first_pc = '0; first_instr = '0;
    for (int i = 0; i < 20 && !got_de; i++) begin
      cycle();
      if (acc_seen && !got_acc) begin
        got_acc    = 1'b1;
        first_addr = addr_seen;
      end
      if (de_instr != NOP) begin
        if (de_pc == bad_a || de_pc == bad_b) bad_seen = 1'b1;
        got_de      = 1'b1;
        first_pc    = de_pc;
        first_instr = de_instr;
      end
    end
    check({tag, "_issued"}, {31'b0, got_acc}, 32'd1);
    check({tag, "_first_addr"}, first_addr, tgt);
    check({tag, "_delivered"}, {31'b0, got_de}, 32'd1);
    check({tag, "_first_pc"}, first_pc, tgt);
    check({tag, "_first_instr"}, first_instr, mem_word(tgt));
    check({tag, "_no_wrong_path"}, {31'b0, bad_seen}, 32'd0);
    check({tag, "_drop_cnt_zero"}, 32'(dut.drop_cnt_q), 32'd0);
  endtask

  typedef struct {
    logic        rdy;
    logic        stall;
    logic        clr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_empty;
  } vec_t;

  vec_t vt[19];

  initial begin
    // 5 cycles memory-not-ready, then 1-cycle memory with a 3-cycle stall.
    for (int i = 0; i < 5; i++) vt[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, NOP, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 32'h00, NOP,          1'b1};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h04, 32'h00, NOP,          1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h00, 32'hA000_0000, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h08, 32'h04, 32'hA000_0004, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0C, 32'h00, NOP,          1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h08, 32'hA000_0008, 1'b0};
    vt[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h08, 32'hA000_0008, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 32'h08, 32'hA000_0008, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 32'h08, 32'hA000_0008, 1'b0};
    vt[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0C, 32'hA000_000C, 1'b0};
    vt[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h14, 32'h10, 32'hA000_0010, 1'b1};
    vt[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h18, 32'h00, NOP,          1'b0};
    vt[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h14, 32'hA000_0014, 1'b0};
    vt[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h1C, 32'h18, 32'hA000_0018, 1'b1};

    // Reset state
    do_reset(1);
    rst_n = 1'b0;
    cycle();
    check("rst_req", {31'b0, req_seen}, 32'd0);
    check("rst_instr", de_instr, NOP);
    check("rst_pc", de_pc, 32'h0);
    check("rst_pc4", de_pc_plus4, 32'h0);
    check("rst_empty", {31'b0, fetch_empty}, 32'd1);
    rst_n = 1'b1;

    // Table: ready-low hold, stream, stall with full queue
    for (int i = 0; i < 19; i++) begin
      imem_ready = vt[i].rdy;
      de_stall   = vt[i].stall;
      de_clear   = vt[i].clr;
      ex_pc_src  = 1'b0;
      cycle();
      check($sformatf("vec%0d_req", i), {31'b0, req_seen}, {31'b0, vt[i].exp_req});
      if (vt[i].exp_req) check($sformatf("vec%0d_addr", i), addr_seen, vt[i].exp_addr);
      check($sformatf("vec%0d_pc", i), de_pc, vt[i].exp_pc);
      check($sformatf("vec%0d_instr", i), de_instr, vt[i].exp_instr);
      check($sformatf("vec%0d_pc4", i), de_pc_plus4,
            (vt[i].exp_instr == NOP) ? 32'h0 : vt[i].exp_pc + 32'd4);
      check($sformatf("vec%0d_empty", i), {31'b0, fetch_empty}, {31'b0, vt[i].exp_empty});
    end
    de_stall = 1'b0;

    // Latency 3: redirect with PC 8 and C outstanding
    do_reset(3);
    repeat (6) cycle();
    check("lat3_pre_pc", de_pc, 32'h4);
    check("lat3_pre_instr", de_instr, 32'hA000_0004);
    cycle();
    ex_pc_src    = 1'b1;
    ex_pc_target = 32'h0000_0100;
    cycle();
    check("lat3_redir_req", {31'b0, req_seen}, 32'd0);
    check("lat3_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    ex_pc_src = 1'b0;
    follow_redirect("lat3", 32'h0000_0100, 32'h8, 32'hC);

    // Redirect coinciding with the response for PC 8 (misaligned target)
    do_reset(1);
    repeat (4) cycle();
    check("same_pre_pc", de_pc, 32'h4);
    ex_pc_src    = 1'b1;
    ex_pc_target = 32'h0000_0203;
    cycle();
    check("same_rvalid", {31'b0, rvalid_seen}, 32'd1);
    check("same_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
    ex_pc_src = 1'b0;
    follow_redirect("same", 32'h0000_0200, 32'h8, 32'h8);

    // de_clear and de_stall together: bubble, head retained
    do_reset(1);
    repeat (3) cycle();
    check("clr_pre_instr", de_instr, 32'hA000_0000);
    de_clear = 1'b1;
    de_stall = 1'b1;
    cycle();
    check("clr_instr", de_instr, NOP);
    check("clr_pc", de_pc, 32'h0);
    check("clr_pc4", de_pc_plus4, 32'h0);
    check("clr_empty", {31'b0, fetch_empty}, 32'd0);
    de_clear = 1'b0;
    de_stall = 1'b0;
    cycle();
    check("clr_next_pc", de_pc, 32'h4);
    check("clr_next_instr", de_instr, 32'hA000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
